// File: rtl/uart_tx_frame_if.sv
// Byte-push handshake and serial-line bundle for uart_tx_frame.
// The master side pushes bytes; the slave side (the transmitter) drives the line and status.
interface uart_tx_frame_if #(
  parameter int DEPTH = 4
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          ser_tx;
  logic          busy;
  logic [LW-1:0] fifo_level;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, ser_tx, busy, fifo_level
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, ser_tx, busy, fifo_level
  );
endinterface

// File: rtl/uart_tx_frame.sv
// 8N1 UART transmitter with a DEPTH-entry input FIFO and a fixed CLK_DIV baud divider.
// Define UART_TX_PARITY_EN for 8E1 framing (even-parity bit inserted between data and stop).
module uart_tx_frame #(
  parameter int CLK_DIV = 4167,
  parameter int DEPTH   = 4
) (
  input  logic           clock,
  input  logic           reset,
  uart_tx_frame_if.slave bus
);
  localparam int              AW       = $clog2(DEPTH);
  localparam int              LW       = AW + 1;
  localparam logic [15:0]     DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [LW-1:0]   LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]   LVL_ZERO = {LW{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_e;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          ready_q;
  state_e        state_q;
  logic [15:0]   div_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          ser_q;
  logic          busy_q;
  logic          push_s;
  logic          pop_s;
  logic          bit_end_s;
  logic          line_s;

  assign push_s    = bus.tx_valid && ready_q;
  assign bit_end_s = (div_q == DIV_LAST);

  assign bus.tx_ready   = ready_q;
  assign bus.ser_tx     = ser_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_level = level_q;

  // Head is popped when leaving IDLE or at the end of a stop bit with bytes waiting.
  always_comb begin
    pop_s = 1'b0;
    if (level_q != LVL_ZERO) begin
      if (state_q == ST_IDLE) begin
        pop_s = 1'b1;
      end else if ((state_q == ST_STOP) && bit_end_s) begin
        pop_s = 1'b1;
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // FIFO occupancy after this cycle's push and pop.
  always_comb begin
    level_d = level_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Line value implied by the current state; registered one clock later.
  always_comb begin
    line_s = 1'b1;
    case (state_q)
      ST_START:  line_s = 1'b0;
      ST_DATA:   line_s = shift_q[bit_q];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: line_s = even_parity(shift_q);
`endif
      default:   line_s = 1'b1;
    endcase
  end

  // FIFO storage, pointers and level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= LVL_ZERO;
      ready_q  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= bus.tx_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
      ready_q <= (level_d != LVL_FULL);
    end
  end

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      ser_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      ser_q  <= line_s;
      busy_q <= (state_q != ST_IDLE) || (level_q != LVL_ZERO);
      div_q  <= bit_end_s ? 16'd0 : (div_q + 16'd1);
      case (state_q)
        ST_IDLE: begin
          div_q <= 16'd0;
          if (pop_s) begin
            state_q <= ST_START;
            shift_q <= mem_q[rd_ptr_q];
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            state_q <= ST_DATA;
            bit_q   <= 3'd0;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end_s) begin
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end_s) begin
            if (pop_s) begin
              state_q <= ST_START;
              shift_q <= mem_q[rd_ptr_q];
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: a fast instance (CLK_DIV=4) plus a default-rate instance.
`timescale 1ns/1ps
module tb_uart_tx_frame;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int DIV2  = 4167;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  uart_tx_frame_if #(.DEPTH(DEPTH)) if1 ();
  uart_tx_frame_if #(.DEPTH(4))     if2 ();

  uart_tx_frame #(.CLK_DIV(DIV), .DEPTH(DEPTH)) dut  (.clock(clk), .reset(rst),  .bus(if1));
  uart_tx_frame                                 dut2 (.clock(clk), .reset(rst2), .bus(if2));

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc   = 0;
  logic [7:0] sb_q[$];
  int         starts_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Serial receiver on the fast instance; pops the scoreboard at each stop bit.
  initial begin : rx_mon
    logic        rx_act;
    int          rx_cnt;
    int          rx_b;
    logic [7:0]  rx_byte;
    logic [31:0] rx_exp;
    rx_act = 1'b0;
    rx_cnt = 0;
    rx_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_act = 1'b0;
      end else if (!rx_act) begin
        if (if1.ser_tx === 1'b0) begin
          rx_act = 1'b1;
          rx_cnt = 0;
          rx_byte = 8'h00;
          starts_q.push_back(cyc);
        end
      end else begin
        rx_cnt = rx_cnt + 1;
        if ((rx_cnt % DIV) == (DIV / 2)) begin
          rx_b = rx_cnt / DIV;
          if (rx_b == 0) begin
            check_eq("rx_start", {31'd0, if1.ser_tx}, 32'd0);
          end else if (rx_b <= 8) begin
            rx_byte[rx_b-1] = if1.ser_tx;
          end else if (rx_b < FB - 1) begin
            check_eq("rx_parity", {31'd0, if1.ser_tx}, {31'd0, ^rx_byte});
          end else begin
            check_eq("rx_stop", {31'd0, if1.ser_tx}, 32'd1);
            rx_exp = (sb_q.size() != 0) ? {24'd0, sb_q.pop_front()} : 32'hFFFF_FFFF;
            check_eq("rx_byte", {24'd0, rx_byte}, rx_exp);
            rx_act = 1'b0;
          end
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] d);
    if1.tx_data  = d;
    if1.tx_valid = 1'b1;
    sb_q.push_back(d);
    @(negedge clk);
    if1.tx_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int maxc);
    int t;
    t = 0;
    while (((sb_q.size() != 0) || (if1.busy !== 1'b0)) && (t < maxc)) begin
      @(negedge clk);
      t++;
    end
    check_eq(tag, (t >= maxc) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic run_dut1();
    int         bad_s, bad_b, bad_r, t, idx, max_lvl, bad_rdy;
    int         acc_cyc[$];
    logic       acc, exp_s;
    repeat (3) @(negedge clk);
    check_eq("rst_ser",   {31'd0, if1.ser_tx},   32'd1);
    check_eq("rst_ready", {31'd0, if1.tx_ready}, 32'd1);
    check_eq("rst_busy",  {31'd0, if1.busy},     32'd0);
    check_eq("rst_level", {29'd0, if1.fifo_level}, 32'd0);
    rst = 1'b0;

    bad_s = 0; bad_b = 0; bad_r = 0;
    repeat (1000) begin
      @(negedge clk);
      if (if1.ser_tx   !== 1'b1) bad_s++;
      if (if1.busy     !== 1'b0) bad_b++;
      if (if1.tx_ready !== 1'b1) bad_r++;
    end
    check_eq("idle_ser",   bad_s, 32'd0);
    check_eq("idle_busy",  bad_b, 32'd0);
    check_eq("idle_ready", bad_r, 32'd0);

    // single byte: exact per-cycle waveform and busy window
    push_byte(8'hA5);
    check_eq("t1_level_push", {29'd0, if1.fifo_level}, 32'd1);
    for (int k = 1; k <= DIV * FB + 4; k++) begin
      @(negedge clk);
      exp_s = ((k >= 2) && (k < 2 + DIV * FB)) ? frame_bit(8'hA5, (k - 2) / DIV) : 1'b1;
      check_eq("t1_ser",  {31'd0, if1.ser_tx}, {31'd0, exp_s});
      check_eq("t1_busy", {31'd0, if1.busy}, (k <= DIV * FB + 1) ? 32'd1 : 32'd0);
    end
    check_eq("t1_level_end", {29'd0, if1.fifo_level}, 32'd0);
    check_eq("t1_sb_empty", sb_q.size(), 32'd0);

    // streaming six bytes with tx_valid held high
    starts_q.delete();
    idx = 1; t = 0; max_lvl = 0; bad_rdy = 0;
    if1.tx_data = 8'h01; if1.tx_valid = 1'b1;
    while ((idx <= 6) && (t < 600)) begin
      acc = if1.tx_ready;
      @(negedge clk);
      t++;
      if (acc) begin
        sb_q.push_back(if1.tx_data);
        acc_cyc.push_back(t);
        idx++;
        if1.tx_data = 8'(idx);
      end
      if (int'(if1.fifo_level) > max_lvl) max_lvl = int'(if1.fifo_level);
      if (if1.tx_ready !== (int'(if1.fifo_level) != DEPTH)) bad_rdy++;
    end
    if1.tx_valid = 1'b0;
    check_eq("t2_all_accepted", idx, 32'd7);
    check_eq("t2_max_level", max_lvl, DEPTH);
    check_eq("t2_ready_rule", bad_rdy, 32'd0);
    check_eq("t2_byte6_cycle", (acc_cyc.size() == 6) ? (acc_cyc[5] - acc_cyc[0]) : -1, DIV * FB + 2);
    drain("t2_drain", 2000);
    check_eq("t2_frames", starts_q.size(), 32'd6);
    for (int i = 1; i < starts_q.size(); i++) begin
      check_eq("t2_gap", starts_q[i] - starts_q[i-1], DIV * FB);
    end

    // reset during data bit 3 with a second byte still queued
    if1.tx_data = 8'h3C; if1.tx_valid = 1'b1;
    @(negedge clk);
    if1.tx_data = 8'h99;
    @(negedge clk);
    if1.tx_valid = 1'b0;
    repeat (18) @(negedge clk);
    check_eq("t3_pre_busy",  {31'd0, if1.busy}, 32'd1);
    check_eq("t3_pre_level", {29'd0, if1.fifo_level}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("t3_rst_ser",   {31'd0, if1.ser_tx}, 32'd1);
    check_eq("t3_rst_level", {29'd0, if1.fifo_level}, 32'd0);
    check_eq("t3_rst_busy",  {31'd0, if1.busy}, 32'd0);
    check_eq("t3_rst_ready", {31'd0, if1.tx_ready}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    bad_s = 0; bad_b = 0;
    repeat (100) begin
      @(negedge clk);
      if (if1.ser_tx !== 1'b1) bad_s++;
      if (if1.busy   !== 1'b0) bad_b++;
    end
    check_eq("t3_quiet_ser",  bad_s, 32'd0);
    check_eq("t3_quiet_busy", bad_b, 32'd0);
    push_byte(8'h5A);
    drain("t3_drain", 500);

    // parity-relevant bytes; also frame length
    starts_q.delete();
    push_byte(8'h07);
    push_byte(8'h03);
    drain("t4_drain", 500);
    check_eq("t4_frames", starts_q.size(), 32'd2);
    check_eq("t4_frame_len", (starts_q.size() == 2) ? (starts_q[1] - starts_q[0]) : -1, DIV * FB);
  endtask

  task automatic run_dut2();
    logic [7:0] exp_b, got;
    int         t;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    if2.tx_data = 8'h00; if2.tx_valid = 1'b1;
    @(negedge clk);
    if2.tx_data = 8'hFF;
    @(negedge clk);
    if2.tx_valid = 1'b0;
    for (int f = 0; f < 2; f++) begin
      exp_b = (f == 0) ? 8'h00 : 8'hFF;
      t = 0;
      while ((if2.ser_tx !== 1'b0) && (t < 3 * DIV2)) begin
        @(negedge clk);
        t++;
      end
      check_eq("rx2_start_wait", (t < 3 * DIV2) ? 32'd0 : 32'd1, 32'd0);
      repeat (DIV2 / 2) @(negedge clk);
      check_eq("rx2_start", {31'd0, if2.ser_tx}, 32'd0);
      got = 8'h00;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV2) @(negedge clk);
        got[i] = if2.ser_tx;
      end
`ifdef UART_TX_PARITY_EN
      repeat (DIV2) @(negedge clk);
      check_eq("rx2_parity", {31'd0, if2.ser_tx}, {31'd0, ^exp_b});
`endif
      repeat (DIV2) @(negedge clk);
      check_eq("rx2_stop", {31'd0, if2.ser_tx}, 32'd1);
      check_eq("rx2_byte", {24'd0, got}, {24'd0, exp_b});
    end
    t = 0;
    while ((if2.busy !== 1'b0) && (t < 3 * DIV2)) begin
      @(negedge clk);
      t++;
    end
    check_eq("rx2_busy_end", {31'd0, if2.busy}, 32'd0);
  endtask

  initial begin
    if1.tx_valid = 1'b0;
    if1.tx_data  = 8'h00;
    if2.tx_valid = 1'b0;
    if2.tx_data  = 8'h00;
    fork
      run_dut1();
      run_dut2();
    join
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1300000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end
endmodule
